// File: rtl/trace_capture.sv
// Instruction trace capture: arm, trigger on an opcode, then log POST_COUNT retire records into a FWFT FIFO.
// Records are stored one edge after retirement; the head is visible the cycle after that, and records produced while full are dropped and flagged.
module trace_capture #(
   parameter int DEPTH      = 16,
   parameter int POST_COUNT = 12
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic [7:0]              in_pc,
   input  logic [5:0]              in_opcode,
   input  logic [31:0]             in_result,
   input  logic                    arm,
   input  logic                    clear,
   input  logic [5:0]              trig_opcode,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [7:0]              out_pc,
   output logic [5:0]              out_opcode,
   output logic [31:0]             out_result,
   output logic [15:0]             out_stamp,
   output logic [$clog2(DEPTH):0]  count,
   output logic [1:0]              state,
   output logic                    overflow
);
   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [7:0]  pc;
      logic [5:0]  opcode;
      logic [31:0] result;
      logic [15:0] stamp;
   } rec_t;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      ARMED   = 2'b01,
      CAPTURE = 2'b10,
      STOPPED = 2'b11
   } state_t;

   rec_t          mem_q [DEPTH];
   state_t        state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          overflow_q, overflow_d;
   logic [15:0]   stamp_q, stamp_d;
   logic [15:0]   prod_q, prod_d;

   logic          trig_hit, produce, full, wr_en, pop;
   rec_t          wr_rec, head_rec;

   always_comb begin
      trig_hit = in_valid && (in_opcode == trig_opcode);
      produce  = ((state_q == ARMED) && trig_hit) || ((state_q == CAPTURE) && in_valid);
      // Fullness is judged on the pre-pop occupancy, so a same-cycle read never frees a slot.
      full     = (count_q == (AW+1)'(DEPTH));
      wr_en    = produce && !full && !clear;
      pop      = (count_q != '0) && out_ready && !clear;

      wr_rec.pc     = in_pc;
      wr_rec.opcode = in_opcode;
      wr_rec.result = in_result;
      wr_rec.stamp  = (state_q == ARMED) ? 16'd0 : stamp_q;

      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      stamp_d    = stamp_q;
      prod_d     = prod_q;

      if (clear) begin
         state_d    = IDLE;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
         stamp_d    = '0;
         prod_d     = '0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
         case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
         if (produce && full) overflow_d = 1'b1;

         case (state_q)
            IDLE: begin
               if (arm) state_d = ARMED;
            end
            ARMED: begin
               if (trig_hit) begin
                  prod_d  = 16'd1;
                  stamp_d = 16'd1;
                  state_d = (POST_COUNT == 1) ? STOPPED : CAPTURE;
               end
            end
            CAPTURE: begin
               if (stamp_q != 16'hFFFF) stamp_d = stamp_q + 16'd1;
               // Idle retire slots advance time but not the record budget.
               if (in_valid) begin
                  prod_d = prod_q + 16'd1;
                  if (prod_q == 16'(POST_COUNT - 1)) state_d = STOPPED;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         stamp_q    <= '0;
         prod_q     <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         stamp_q    <= stamp_d;
         prod_q     <= prod_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= wr_rec;
   end

   assign head_rec   = mem_q[rd_ptr_q];
   assign out_valid  = (count_q != '0);
   assign out_pc     = head_rec.pc;
   assign out_opcode = head_rec.opcode;
   assign out_result = head_rec.result;
   assign out_stamp  = head_rec.stamp;
   assign count      = count_q;
   assign state      = state_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_trace_capture.sv
// Bench for trace_capture: three instances (16/12, 16/20, 4/10) on shared inputs, checked against a queue model.
module tb_trace_capture;
   localparam logic [5:0] TRIG = 6'b010011;

   typedef struct packed {
      logic [7:0]  pc;
      logic [5:0]  op;
      logic [31:0] res;
      logic [15:0] stamp;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_pc = '0;
   logic [5:0]  in_opcode = '0;
   logic [31:0] in_result = '0;
   logic        arm = 1'b0;
   logic        clear = 1'b0;
   logic [5:0]  trig_opcode = TRIG;
   logic        rdy [3];

   logic        ovld  [3];
   logic [7:0]  opc   [3];
   logic [5:0]  oop   [3];
   logic [31:0] ores  [3];
   logic [15:0] ostmp [3];
   logic [4:0]  ocnt0, ocnt1;
   logic [2:0]  ocnt2;
   logic [1:0]  ost   [3];
   logic        oovf  [3];

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 0;

   always #5 clk = ~clk;

   trace_capture #(.DEPTH(16), .POST_COUNT(12)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_opcode(in_opcode),
      .in_result(in_result), .arm(arm), .clear(clear), .trig_opcode(trig_opcode),
      .out_valid(ovld[0]), .out_ready(rdy[0]), .out_pc(opc[0]), .out_opcode(oop[0]),
      .out_result(ores[0]), .out_stamp(ostmp[0]), .count(ocnt0), .state(ost[0]), .overflow(oovf[0]));

   trace_capture #(.DEPTH(16), .POST_COUNT(20)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_opcode(in_opcode),
      .in_result(in_result), .arm(arm), .clear(clear), .trig_opcode(trig_opcode),
      .out_valid(ovld[1]), .out_ready(rdy[1]), .out_pc(opc[1]), .out_opcode(oop[1]),
      .out_result(ores[1]), .out_stamp(ostmp[1]), .count(ocnt1), .state(ost[1]), .overflow(oovf[1]));

   trace_capture #(.DEPTH(4), .POST_COUNT(10)) u2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_opcode(in_opcode),
      .in_result(in_result), .arm(arm), .clear(clear), .trig_opcode(trig_opcode),
      .out_valid(ovld[2]), .out_ready(rdy[2]), .out_pc(opc[2]), .out_opcode(oop[2]),
      .out_result(ores[2]), .out_stamp(ostmp[2]), .count(ocnt2), .state(ost[2]), .overflow(oovf[2]));

   function automatic int dep(int k);
      return (k == 2) ? 4 : 16;
   endfunction

   function automatic int post(int k);
      case (k)
         0:       return 12;
         1:       return 20;
         default: return 10;
      endcase
   endfunction

   function automatic logic [4:0] cnt_of(int k);
      case (k)
         0:       return ocnt0;
         1:       return ocnt1;
         default: return {2'b00, ocnt2};
      endcase
   endfunction

   // ---- behavioural model: one queue per instance, stamps from absolute cycle numbers ----
   rec_t   q0[$], q1[$], q2[$];
   int     m_state [3] = '{0, 0, 0};
   int     m_prod  [3] = '{0, 0, 0};
   bit     m_ovf   [3] = '{0, 0, 0};
   longint m_trig  [3] = '{0, 0, 0};
   longint cyc = 0;

   function automatic int q_size(int k);
      case (k)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic rec_t q_front(int k);
      case (k)
         0:       return q0[0];
         1:       return q1[0];
         default: return q2[0];
      endcase
   endfunction

   function automatic void q_pop(int k);
      case (k)
         0:       void'(q0.pop_front());
         1:       void'(q1.pop_front());
         default: void'(q2.pop_front());
      endcase
   endfunction

   function automatic void q_push(int k, rec_t r);
      case (k)
         0:       q0.push_back(r);
         1:       q1.push_back(r);
         default: q2.push_back(r);
      endcase
   endfunction

   function automatic void q_clear(int k);
      case (k)
         0:       q0.delete();
         1:       q1.delete();
         default: q2.delete();
      endcase
   endfunction

   function automatic void m_reset(int k);
      q_clear(k);
      m_state[k] = 0;
      m_prod[k]  = 0;
      m_ovf[k]   = 0;
   endfunction

   task automatic m_step(int k);
      rec_t   r;
      bit     prod;
      bit     full;
      longint age;
      if (clear) begin
         m_reset(k);
         return;
      end
      full = (q_size(k) >= dep(k));
      prod = 0;
      if (q_size(k) > 0 && rdy[k]) q_pop(k);
      case (m_state[k])
         0: if (arm) m_state[k] = 1;
         1: if (in_valid && in_opcode == trig_opcode) begin
               prod        = 1;
               m_trig[k]   = cyc;
               m_prod[k]   = 1;
               m_state[k]  = (post(k) == 1) ? 3 : 2;
            end
         2: if (in_valid) begin
               prod      = 1;
               m_prod[k] = m_prod[k] + 1;
               if (m_prod[k] == post(k)) m_state[k] = 3;
            end
         default: ;
      endcase
      if (prod) begin
         age     = cyc - m_trig[k];
         r.pc    = in_pc;
         r.op    = in_opcode;
         r.res   = in_result;
         r.stamp = (age > 65535) ? 16'hFFFF : 16'(age);
         if (full) m_ovf[k] = 1;
         else      q_push(k, r);
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 3; k++) m_reset(k);
      end else begin
         for (int k = 0; k < 3; k++) m_step(k);
         cyc = cyc + 1;
      end
   end

   task automatic chk(string nm, int k, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL u%0d %s: got %0h expected %0h (t=%0t)", k, nm, act, exp, $time);
      end
   endtask

   // ---- per-cycle compare against the model, away from the active edge ----
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         for (int k = 0; k < 3; k++) begin
            rec_t h;
            chk("out_valid", k, 64'(ovld[k]), 64'(q_size(k) != 0));
            chk("count",     k, 64'(cnt_of(k)), 64'(q_size(k)));
            chk("state",     k, 64'(ost[k]), 64'(m_state[k]));
            chk("overflow",  k, 64'(oovf[k]), 64'(m_ovf[k]));
            if (q_size(k) != 0) begin
               h = q_front(k);
               chk("out_pc",     k, 64'(opc[k]),   64'(h.pc));
               chk("out_opcode", k, 64'(oop[k]),   64'(h.op));
               chk("out_result", k, 64'(ores[k]),  64'(h.res));
               chk("out_stamp",  k, 64'(ostmp[k]), 64'(h.stamp));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(bit v, logic [5:0] op);
      in_valid  = v;
      in_opcode = op;
      in_pc     = 8'($urandom);
      in_result = $urandom;
   endtask

   logic [7:0] exp_pc[$];
   int rx0, rx2;

   initial begin
      for (int k = 0; k < 3; k++) rdy[k] = 1'b0;
      #1 rst = 1'b1;
      #2;
      chk("rst count",    0, 64'(ocnt0),   64'd0);
      chk("rst valid",    0, 64'(ovld[0]), 64'd0);
      chk("rst state",    0, 64'(ost[0]),  64'd0);
      chk("rst overflow", 0, 64'(oovf[0]), 64'd0);
      #9 rst = 1'b0;
      chk_en = 1;

      // Trigger after a non-matching opcode, nothing drained.
      arm = 1'b1; drive(0, 6'd0); tick(); arm = 1'b0;
      drive(1, 6'b000000); tick();
      drive(1, TRIG); tick();
      for (int i = 0; i < 11; i++) begin drive(1, 6'b000110); tick(); end
      chk("A count",     0, 64'(ocnt0),    64'd12);
      chk("A state",     0, 64'(ost[0]),   64'd3);
      chk("A overflow",  0, 64'(oovf[0]),  64'd0);
      chk("A head op",   0, 64'(oop[0]),   64'(TRIG));
      chk("A head stamp",0, 64'(ostmp[0]), 64'd0);
      for (int i = 0; i < 7; i++) begin drive(1, 6'b000110); tick(); end
      chk("A pre-stop state", 1, 64'(ost[1]), 64'd2);
      drive(1, 6'b000110); tick();
      chk("A count sat", 1, 64'(ocnt1),   64'd16);
      chk("A overflow",  1, 64'(oovf[1]), 64'd1);
      chk("A state",     1, 64'(ost[1]),  64'd3);
      drive(0, 6'd0);
      for (int k = 0; k < 3; k++) rdy[k] = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("A drain valid", 1, 64'(ovld[1]),  64'd1);
         chk("A drain stamp", 1, 64'(ostmp[1]), 64'(i));
         tick();
      end
      chk("A drained", 1, 64'(ocnt1), 64'd0);

      // Streaming read with gaps; small instance wraps its pointers with toggling ready.
      clear = 1'b1; tick(); clear = 1'b0;
      arm = 1'b1; tick(); arm = 1'b0;
      rdy[0] = 1'b1; rdy[2] = 1'b0;
      rx0 = 0; rx2 = 0;
      exp_pc.delete();
      drive(1, TRIG); exp_pc.push_back(in_pc); tick();
      for (int i = 0; i < 48; i++) begin
         if (ovld[0]) begin
            chk("B pc order", 0, 64'(opc[0]), 64'(exp_pc[rx0]));
            rx0++;
         end
         chk("B count<=1", 0, 64'(ocnt0 <= 5'd1), 64'd1);
         rdy[1] = 1'($urandom);
         rdy[2] = (i % 2 == 0);
         if (ovld[2] && rdy[2]) rx2++;
         drive(i % 2 == 1, 6'b000110);
         if (in_valid && exp_pc.size() < 12) exp_pc.push_back(in_pc);
         tick();
      end
      chk("B received", 0, 64'(rx0), 64'd12);
      chk("B received", 2, 64'(rx2), 64'd10);
      chk("B overflow", 2, 64'(oovf[2]), 64'd0);

      // Clear against arm, a write and a pop in the same cycle.
      for (int k = 0; k < 3; k++) rdy[k] = 1'b0;
      drive(0, 6'd0);
      clear = 1'b1; tick(); clear = 1'b0;
      arm = 1'b1; tick(); arm = 1'b0;
      drive(1, TRIG); tick();
      for (int i = 0; i < 4; i++) begin drive(1, 6'd7); tick(); end
      chk("D count", 0, 64'(ocnt0), 64'd5);
      clear = 1'b1; arm = 1'b1; drive(1, 6'd7);
      for (int k = 0; k < 3; k++) rdy[k] = 1'b1;
      tick();
      clear = 1'b0; arm = 1'b0; drive(0, 6'd0);
      for (int k = 0; k < 3; k++) rdy[k] = 1'b0;
      chk("D count",    0, 64'(ocnt0),   64'd0);
      chk("D state",    0, 64'(ost[0]),  64'd0);
      chk("D overflow", 0, 64'(oovf[0]), 64'd0);
      chk("D overflow", 2, 64'(oovf[2]), 64'd0);

      // Asynchronous reset mid-capture, then a trigger with no new arm.
      arm = 1'b1; tick(); arm = 1'b0;
      drive(1, TRIG); tick();
      for (int i = 0; i < 7; i++) begin drive(1, 6'd9); tick(); end
      #2 rst = 1'b1;
      #1;
      chk("E rst count",    0, 64'(ocnt0),   64'd0);
      chk("E rst valid",    0, 64'(ovld[0]), 64'd0);
      chk("E rst state",    0, 64'(ost[0]),  64'd0);
      chk("E rst overflow", 0, 64'(oovf[0]), 64'd0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(1, TRIG); tick();
         chk("E no-arm count", 0, 64'(ocnt0),  64'd0);
         chk("E no-arm state", 0, 64'(ost[0]), 64'd0);
      end

      // Random traffic, model-checked every cycle.
      for (int i = 0; i < 3000; i++) begin
         arm   = ($urandom_range(7) == 0);
         clear = ($urandom_range(63) == 0);
         drive($urandom_range(3) != 0, ($urandom_range(4) == 0) ? TRIG : 6'($urandom));
         for (int k = 0; k < 3; k++) rdy[k] = ($urandom_range(2) != 0);
         tick();
      end
      arm = 1'b0; clear = 1'b0; drive(0, 6'd0);
      tick();
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
